// File: rtl/aqp_ovl_console.sv
// Byte-stream console front end for the 40x25 overlay text plane: cursor, control codes, clear fill.
// Define OVL_CONSOLE_ATTR_EN to enable the ESC <attr> sequence that changes the write attribute.
module aqp_ovl_console #(
  parameter logic [7:0] DEFAULT_ATTR = 8'h1F,
  parameter int         COLS         = 40,
  parameter int         ROWS         = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic [9:0]  ovl_text_addr,
  output logic [15:0] ovl_text_wrdata,
  output logic        ovl_text_wr
);

  localparam logic [5:0] LAST_COL   = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW   = 5'(ROWS - 1);
  localparam logic [9:0] LAST_ADDR  = 10'(COLS * ROWS - 1);
  localparam logic [9:0] ROW_STRIDE = 10'(COLS);
  localparam logic [7:0] SPACE      = 8'h20;

`ifdef OVL_CONSOLE_ATTR_EN
  typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_CLEAR, ST_ESC} state_t;
`else
  typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_CLEAR} state_t;
`endif

  state_t      state_q;
  logic [5:0]  col_q;
  logic [4:0]  row_q;
  logic [9:0]  lin_q;
  logic [7:0]  attr_q;
  logic        ready_q;
  logic        busy_q;
  logic        wr_q;
  logic [9:0]  addr_q;
  logic [15:0] wrdata_q;

  logic       accept_d;
  logic       startClear_d;
  logic [5:0] advCol_d;
  logic [4:0] advRow_d;
  logic [9:0] advLin_d;
  logic [5:0] bsCol_d;
  logic [4:0] bsRow_d;
  logic [9:0] bsLin_d;
  logic [4:0] lfRow_d;
  logic [9:0] lfLin_d;
  logic [9:0] crLin_d;

  // Candidate cursor moves; lin_q tracks row*COLS+col incrementally so no multiplier is needed.
  always_comb begin
    accept_d     = in_valid && ready_q;
    startClear_d = (state_q == ST_RESET) ||
                   ((state_q == ST_IDLE) && accept_d && (in_data == 8'h0C));

    if (col_q == LAST_COL) begin
      advCol_d = 6'd0;
      advRow_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    end else begin
      advCol_d = col_q + 6'd1;
      advRow_d = row_q;
    end
    advLin_d = (lin_q == LAST_ADDR) ? 10'd0 : lin_q + 10'd1;

    bsCol_d = col_q;
    bsRow_d = row_q;
    bsLin_d = lin_q;
    if (col_q != 6'd0) begin
      bsCol_d = col_q - 6'd1;
      bsLin_d = lin_q - 10'd1;
    end else if (row_q != 5'd0) begin
      bsCol_d = LAST_COL;
      bsRow_d = row_q - 5'd1;
      bsLin_d = lin_q - 10'd1;
    end

    if (row_q == LAST_ROW) begin
      lfRow_d = 5'd0;
      lfLin_d = {4'd0, col_q};
    end else begin
      lfRow_d = row_q + 5'd1;
      lfLin_d = lin_q + ROW_STRIDE;
    end
    crLin_d = lin_q - {4'd0, col_q};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_RESET;
      col_q    <= 6'd0;
      row_q    <= 5'd0;
      lin_q    <= 10'd0;
      attr_q   <= DEFAULT_ATTR;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 10'd0;
      wrdata_q <= 16'd0;
    end else begin
      wr_q <= 1'b0;
      if (startClear_d) begin
        // First cycle out of reset starts the same fill as an accepted FF.
        state_q  <= ST_CLEAR;
        ready_q  <= 1'b0;
        busy_q   <= 1'b1;
        wr_q     <= 1'b1;
        addr_q   <= 10'd0;
        wrdata_q <= {attr_q, SPACE};
        col_q    <= 6'd0;
        row_q    <= 5'd0;
        lin_q    <= 10'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept_d) begin
              case (in_data)
                8'h0D: begin
                  col_q <= 6'd0;
                  lin_q <= crLin_d;
                end
                8'h0A: begin
                  row_q <= lfRow_d;
                  lin_q <= lfLin_d;
                end
                8'h08: begin
                  col_q    <= bsCol_d;
                  row_q    <= bsRow_d;
                  lin_q    <= bsLin_d;
                  wr_q     <= 1'b1;
                  addr_q   <= bsLin_d;
                  wrdata_q <= {attr_q, SPACE};
                end
`ifdef OVL_CONSOLE_ATTR_EN
                8'h1B: state_q <= ST_ESC;
`endif
                default: begin
                  wr_q     <= 1'b1;
                  addr_q   <= lin_q;
                  wrdata_q <= {attr_q, in_data};
                  col_q    <= advCol_d;
                  row_q    <= advRow_d;
                  lin_q    <= advLin_d;
                end
              endcase
            end
          end
`ifdef OVL_CONSOLE_ATTR_EN
          ST_ESC: begin
            if (accept_d) begin
              attr_q  <= in_data;
              state_q <= ST_IDLE;
            end
          end
`endif
          ST_CLEAR: begin
            if (addr_q == LAST_ADDR) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              addr_q <= addr_q + 10'd1;
              wr_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready        = ready_q;
  assign busy            = busy_q;
  assign cursor_col      = col_q;
  assign cursor_row      = row_q;
  assign ovl_text_addr   = addr_q;
  assign ovl_text_wrdata = wrdata_q;
  assign ovl_text_wr     = wr_q;

endmodule
